// File: rtl/add_pipe_if.sv
// add_pipe_if -- operand/result handshake bundle for add_pipe.
//   master : drives operands (in_valid, a, b, cin, sub) and out_ready;
//            observes in_ready and the result beat.
//   slave  : the adder; drives in_ready and the result beat
//            (out_valid, sum, cout, ovf, zero).
interface add_pipe_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/add_pipe.sv
// add_pipe -- two-stage pipelined adder/subtractor with valid/ready flow control.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; discards all in-flight beats
//   bus   : add_pipe_if slave port
//           in  : in_valid, a, b, cin, sub, out_ready
//           out : in_ready, out_valid, sum, cout, ovf, zero
// Stage 1 adds the low half and keeps the high operand halves; stage 2 adds
// the high half using the registered low carry and holds the result.
// WIDTH must be a multiple of 8 and at least 8.
module add_pipe #(
  parameter int WIDTH = 64
) (
  input logic       clk,
  input logic       reset,
  add_pipe_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  logic [WIDTH-1:0] be;
  logic             ce;
  logic [HALF:0]    lo_full;

  logic             s1_valid;
  logic [HALF-1:0]  s1_lo_sum;
  logic             s1_lo_carry;
  logic [HALF-1:0]  s1_a_hi;
  logic [HALF-1:0]  s1_be_hi;

  logic [HALF:0]    hi_full;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_cout;
  logic             s2_ovf;
  logic             s2_zero;

  logic             ld2;
  logic             in_xfer;

  // Subtraction is A + ~B + 1; cin is only meaningful for addition.
  always_comb begin
    be      = bus.sub ? ~bus.b : bus.b;
    ce      = bus.sub | bus.cin;
    lo_full = {1'b0, bus.a[HALF-1:0]} + {1'b0, be[HALF-1:0]} + {{HALF{1'b0}}, ce};
  end

  always_comb begin
    hi_full = {1'b0, s1_a_hi} + {1'b0, s1_be_hi} + {{HALF{1'b0}}, s1_lo_carry};
    res     = {hi_full[HALF-1:0], s1_lo_sum};
    res_ovf = (s1_a_hi[HALF-1] == s1_be_hi[HALF-1]) && (res[WIDTH-1] != s1_a_hi[HALF-1]);
  end

  // Stage 2 is free when empty or when its beat leaves on this edge.
  assign ld2          = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !reset && (!s1_valid || ld2);
  assign in_xfer      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (ld2) begin
      s1_valid <= 1'b0;
    end
  end

  // Payload is qualified by s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_lo_sum   <= lo_full[HALF-1:0];
      s1_lo_carry <= lo_full[HALF];
      s1_a_hi     <= bus.a[WIDTH-1:HALF];
      s1_be_hi    <= be[WIDTH-1:HALF];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (ld2) begin
      s2_valid <= 1'b1;
      s2_sum   <= res;
      s2_cout  <= hi_full[HALF];
      s2_ovf   <= res_ovf;
      s2_zero  <= (res == '0);
    end else if (s2_valid && bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.sum       = s2_sum;
  assign bus.cout      = s2_cout;
  assign bus.ovf       = s2_ovf;
  assign bus.zero      = s2_zero;
endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe -- scoreboard bench for add_pipe (WIDTH=64).
// Stimulus pushes the expected {sum,cout,ovf,zero} when a beat is accepted;
// a monitor pops and compares whenever a result beat transfers.
module tb_add_pipe;
  localparam int W = 64;

  logic clk;
  logic reset;
  logic stim_rdy;
  logic rand_rdy;
  logic rnd_bit;

  int checks;
  int failures;

  logic [W+2:0] q[$];

  add_pipe_if #(.WIDTH(W)) bus();

  add_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.out_ready = rand_rdy ? rnd_bit : stim_rdy;

  initial begin
    rnd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bx;
    logic [W:0]   f;
    logic [W-1:0] s;
    logic         ov;
    bx = sub ? ~b : b;
    f  = {1'b0, a} + {1'b0, bx} + (W+1)'(sub | cin);
    s  = f[W-1:0];
    ov = (a[W-1] == bx[W-1]) && (s[W-1] != a[W-1]);
    return {s, f[W], ov, (s == '0)};
  endfunction

  // Monitor: a result transfers on the next edge when out_valid && out_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h expected=none", bus.sum);
        end else begin
          check("result", 80'({bus.sum, bus.cout, bus.ovf, bus.zero}), 80'(q.pop_front()));
        end
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic [W+2:0] exp);
    int n;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%0d expected=<1000", n);
    end else begin
      q.push_back(exp);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W+2:0] exp);
    send(a, b, cin, sub, exp);
    check("latency_edge_k", 80'(bus.out_valid), 80'(0));
    @(posedge clk);
    #1;
    check("latency_edge_k1", 80'(bus.out_valid), 80'(1));
  endtask

  task automatic drain();
    int n;
    rand_rdy = 1'b0;
    stim_rdy = 1'b1;
    n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 80'(n < 2000), 80'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    int acc;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    rand_rdy = 1'b0;
    stim_rdy = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 80'(bus.in_ready), 80'(0));
    check("rst_out_valid", 80'(bus.out_valid), 80'(0));
    check("rst_sum", 80'(bus.sum), 80'(0));
    check("rst_flags", 80'({bus.cout, bus.ovf, bus.zero}), 80'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 80'(bus.in_ready), 80'(1));
    @(posedge clk);
    #1;

    // Directed vectors, expected values worked by hand as {sum,cout,ovf,zero}.
    stim_rdy = 1'b1;
    send_lat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {64'h0, 3'b101});
    send_lat(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {64'h0000_0001_0000_0000, 3'b000});
    send_lat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, {64'h8000_0000_0000_0000, 3'b010});
    send_lat(64'd5, 64'd7, 1'b1, 1'b1, {64'hFFFF_FFFF_FFFF_FFFE, 3'b000});
    send_lat(64'd7, 64'd5, 1'b0, 1'b1, {64'd2, 3'b100});
    send_lat(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, {64'h7FFF_FFFF_FFFF_FFFF, 3'b110});
    send_lat(64'd1, 64'd2, 1'b1, 1'b0, {64'd4, 3'b000});
    send_lat(64'd9, 64'd9, 1'b0, 1'b1, {64'd0, 3'b101});
    drain();

    // Stall: out_ready low for 4 cycles with a continuous offer of 6 beats.
    stim_rdy = 1'b0;
    acc = 0;
    held = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc == 4) stim_rdy = 1'b1;
      if (acc < 6) begin
        bus.in_valid = 1'b1;
        bus.a = 64'(100 + acc);
        bus.b = 64'(acc);
        bus.cin = 1'b0;
        bus.sub = 1'b0;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 2) held = bus.sum;
      if (cyc == 3) begin
        check("stall_sum_stable", 80'(bus.sum), 80'(held));
        check("stall_accepted", 80'(acc), 80'(2));
        check("stall_in_ready", 80'(bus.in_ready), 80'(0));
      end
      if (cyc >= 4 && cyc <= 9) check("stall_release_rate", 80'(bus.out_valid), 80'(1));
      if (bus.in_valid && bus.in_ready) begin
        q.push_back({64'(100 + 2 * acc), 3'b000});
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("stall_total_accepted", 80'(acc), 80'(6));
    drain();

    // Reset with two beats in flight.
    stim_rdy = 1'b0;
    send(64'd1, 64'd1, 1'b0, 1'b0, {64'd2, 3'b000});
    send(64'd2, 64'd2, 1'b0, 1'b0, {64'd4, 3'b000});
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 80'(bus.in_ready), 80'(0));
    @(posedge clk);
    #1;
    check("midrst_out_valid", 80'(bus.out_valid), 80'(0));
    check("midrst_sum", 80'(bus.sum), 80'(0));
    reset = 1'b0;
    q.delete();
    stim_rdy = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_after", 80'(bus.in_ready), 80'(1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_stale", 80'(bus.out_valid), 80'(0));
    end
    @(posedge clk);
    #1;
    send_lat(64'd3, 64'd4, 1'b0, 1'b0, {64'd7, 3'b000});
    drain();

    // Random operands with random back-pressure, checked against the model.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ((i % 50) == 0) ra = '1;
      if ((i % 70) == 0) rb = 64'h8000_0000_0000_0000;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
